gat_bram_loader: RTL and testbench
==================================

// Module: gat_bram_loader
// PURPOSE
//  Streaming loader upstream of the GAT top wrapper. Accepts 32-bit words on an AXI-Stream slave and writes
//  them, in fixed region order H-data -> node-info -> weight, to the wrapper's three BRAM write ports.
//  Uses byte addressing: word index * 4. Raises per-region load_done levels consumed by the GAT core.
//  A region mask allows partial reloads, e.g. weights only for the second layer.
// PARAMETERS
//  H_DATA_DEPTH      242101  words in H-data region
//  NODE_INFO_DEPTH   13264   words in node-info region
//  WEIGHT_DEPTH      22928   words in weight region
//  H_DATA_ADDR_W     $clog2(H_DATA_DEPTH)      word address width
//  NODE_INFO_ADDR_W  $clog2(NODE_INFO_DEPTH)   word address width
//  WEIGHT_ADDR_W     $clog2(WEIGHT_DEPTH)      word address width
// PORTS
//  clk                         in   1                   single clock
//  rst_n                       in   1                   asynchronous active-low reset
//  load_start                  in   1                   1-cycle pulse; begins a load sequence
//  load_mask                   in   3                   sampled at load_start; [0]=H, [1]=node-info, [2]=weight
//  s_tdata                     in   32                  stream word
//  s_tvalid                    in   1                   stream valid
//  s_tlast                     in   1                   marks final word of whole sequence
//  s_tready                    out  1                   stream ready
//  h_data_bram_din/ena/wea     out  32/1/1              H-data write port
//  h_data_bram_addra           out  H_DATA_ADDR_W+2     byte address
//  h_node_info_bram_din/ena/wea    out  32/1/1          node-info write port
//  h_node_info_bram_addra      out  NODE_INFO_ADDR_W+2  byte address
//  wgt_bram_din/ena/wea        out  32/1/1              weight write port
//  wgt_bram_addra              out  WEIGHT_ADDR_W+2     byte address
//  h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done   out 1 each   level flags
//  loader_busy                 out  1                   high in any LOAD_* state
//  loader_err                  out  1                   sticky framing error
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; counters 0.
//  FSM states: IDLE, LOAD_H, LOAD_NI, LOAD_W, ERR.
//  IDLE:
//   - On load_start with mask!=0: clear done flags of selected regions and loader_err.
//   - Then enter the first selected state in order H, NI, W.
//   - load_start with mask==0: no effect.
//   - load_start while not in IDLE/ERR: ignored.
//  LOAD_x:
//   - s_tready=1. A beat is accepted when s_tvalid&s_tready.
//   - Each accepted beat produces the next-cycle registered write on that region's port:
//     din=s_tdata, ena=wea=1, addra={word_cnt,2'b00}. Write latency is 1 cycle.
//   - ena/wea are 0 on all cycles with no write.
//   - word_cnt starts at 0 and increments per beat.
//   - On the beat with word_cnt==DEPTH-1: counter resets to 0, then the FSM goes to the next selected
//     region, or to IDLE if none remain.
//   - That region's done flag rises in the same cycle as the final write strobe and holds until reset or
//     reselection.
//  Framing:
//   - s_tlast must be 1 exactly on the final beat of the last selected region.
//   - If s_tlast=1 on any earlier beat: that beat is still written, then go to ERR.
//   - If s_tlast=0 on the final beat: that beat is still written, then go to ERR.
//  ERR:
//   - s_tready=0; loader_err=1.
//   - Done flags of the region in progress and all later regions stay 0.
//   - Only load_start leaves ERR (same rules as IDLE).
//  s_tvalid low stalls with no write and no counter change; back-to-back beats give 1 write/cycle.
//  Asynchronous reset mid-load: abort immediately; flags and counters cleared; partial BRAM contents
//  are undefined.
// TESTING
//  1. Depths 4/3/2, mask=3'b111, 9 continuous beats data=1..9, tlast on beat 9 ->
//     H writes 1..4 at addra 0,4,8,12; NI writes 5..7; W writes 8,9; all three done=1; busy=0.
//  2. mask=3'b100, 2 beats 0xA,0xB with tlast on 2nd -> only wgt port writes (addra 0,4);
//     H/NI done flags keep prior value.
//  3. Toggle s_tvalid every cycle during test 1 -> identical writes, one per valid beat; no spurious ena.
//  4. tlast on beat 3 of test 1 -> beat 3 written; loader_err=1; s_tready=0;
//     all done=0; a new load_start clears err.
//  5. rst_n low during LOAD_NI -> all outputs 0 asynchronously; after release, FSM is in IDLE and
//     accepts a new load_start.
//  6. load_start pulsed while busy -> ignored; sequence completes normally.

Source files
------------

// File: rtl/gat_bram_loader.sv
// Streaming AXI-Stream loader feeding the GAT wrapper's H-data, node-info and weight BRAM write ports.
// Regions are filled in fixed order H -> NI -> W, with a per-load mask selecting which ones are reloaded.
module gat_bram_loader #(
  parameter int H_DATA_DEPTH     = 242101,
  parameter int NODE_INFO_DEPTH  = 13264,
  parameter int WEIGHT_DEPTH     = 22928,
  parameter int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
  parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  parameter int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic [2:0]                  load_mask,
  input  logic [31:0]                 s_tdata,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  output logic [31:0]                 h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [31:0]                 h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [31:0]                 wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
  output logic                        loader_busy,
  output logic                        loader_err
);

  localparam int CNT_W =
    (H_DATA_ADDR_W > NODE_INFO_ADDR_W)
      ? ((H_DATA_ADDR_W > WEIGHT_ADDR_W) ? H_DATA_ADDR_W : WEIGHT_ADDR_W)
      : ((NODE_INFO_ADDR_W > WEIGHT_ADDR_W) ? NODE_INFO_ADDR_W : WEIGHT_ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_H,
    S_LOAD_NI,
    S_LOAD_W,
    S_ERR
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  state_t                      w_first;
  state_t                      w_follow;
  logic [2:0]                  r_mask;
  logic [CNT_W-1:0]            r_cnt;
  logic [2:0]                  r_done;
  logic                        r_h_we;
  logic                        r_ni_we;
  logic                        r_w_we;
  logic [31:0]                 r_h_din;
  logic [31:0]                 r_ni_din;
  logic [31:0]                 r_w_din;
  logic [H_DATA_ADDR_W+1:0]    r_h_addr;
  logic [NODE_INFO_ADDR_W+1:0] r_ni_addr;
  logic [WEIGHT_ADDR_W+1:0]    r_w_addr;
  logic                        w_busy;
  logic                        w_accept;
  logic                        w_start;
  logic                        w_final;
  logic                        w_seq_end;
  logic                        w_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_start = load_start && (load_mask != 3'b000) &&
              ((r_state == S_IDLE) || (r_state == S_ERR));
    w_first = load_mask[0] ? S_LOAD_H : (load_mask[1] ? S_LOAD_NI : S_LOAD_W);

    w_final  = 1'b0;
    w_follow = S_IDLE;
    case (r_state)
      S_LOAD_H: begin
        w_final  = (r_cnt == CNT_W'(H_DATA_DEPTH - 1));
        w_follow = r_mask[1] ? S_LOAD_NI : (r_mask[2] ? S_LOAD_W : S_IDLE);
      end
      S_LOAD_NI: begin
        w_final  = (r_cnt == CNT_W'(NODE_INFO_DEPTH - 1));
        w_follow = r_mask[2] ? S_LOAD_W : S_IDLE;
      end
      S_LOAD_W: w_final = (r_cnt == CNT_W'(WEIGHT_DEPTH - 1));
      default: ;
    endcase

    // tlast is legal only on the last beat of the last selected region, and required there
    w_seq_end   = w_final && (w_follow == S_IDLE);
    w_frame_err = w_accept && (s_tlast != w_seq_end);

    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR: if (w_start) w_next = w_first;
      S_LOAD_H, S_LOAD_NI, S_LOAD_W: begin
        if (w_accept) begin
          if (w_frame_err)  w_next = S_ERR;
          else if (w_final) w_next = w_follow;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state == S_LOAD_H) || (r_state == S_LOAD_NI) || (r_state == S_LOAD_W);
    s_tready    = w_busy;
    loader_busy = w_busy;
    loader_err  = (r_state == S_ERR);
    w_accept    = s_tvalid && w_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= '0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_h_we    <= 1'b0;
      r_ni_we   <= 1'b0;
      r_w_we    <= 1'b0;
      r_h_din   <= '0;
      r_ni_din  <= '0;
      r_w_din   <= '0;
      r_h_addr  <= '0;
      r_ni_addr <= '0;
      r_w_addr  <= '0;
    end else begin
      r_h_we  <= w_accept && (r_state == S_LOAD_H);
      r_ni_we <= w_accept && (r_state == S_LOAD_NI);
      r_w_we  <= w_accept && (r_state == S_LOAD_W);
      if (w_accept && (r_state == S_LOAD_H)) begin
        r_h_din  <= s_tdata;
        r_h_addr <= {r_cnt[H_DATA_ADDR_W-1:0], 2'b00};
      end
      if (w_accept && (r_state == S_LOAD_NI)) begin
        r_ni_din  <= s_tdata;
        r_ni_addr <= {r_cnt[NODE_INFO_ADDR_W-1:0], 2'b00};
      end
      if (w_accept && (r_state == S_LOAD_W)) begin
        r_w_din  <= s_tdata;
        r_w_addr <= {r_cnt[WEIGHT_ADDR_W-1:0], 2'b00};
      end

      if (w_start) begin
        r_mask <= load_mask;
        r_cnt  <= '0;
        r_done <= r_done & ~load_mask;
      end else if (w_accept) begin
        r_cnt <= w_final ? '0 : r_cnt + 1'b1;
        // done rises with the final write strobe, never for a region closed by a framing error
        if (w_final && !w_frame_err) begin
          case (r_state)
            S_LOAD_H:  r_done[0] <= 1'b1;
            S_LOAD_NI: r_done[1] <= 1'b1;
            S_LOAD_W:  r_done[2] <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign h_data_bram_din            = r_h_din;
  assign h_data_bram_ena            = r_h_we;
  assign h_data_bram_wea            = r_h_we;
  assign h_data_bram_addra          = r_h_addr;
  assign h_node_info_bram_din       = r_ni_din;
  assign h_node_info_bram_ena       = r_ni_we;
  assign h_node_info_bram_wea       = r_ni_we;
  assign h_node_info_bram_addra     = r_ni_addr;
  assign wgt_bram_din               = r_w_din;
  assign wgt_bram_ena               = r_w_we;
  assign wgt_bram_wea               = r_w_we;
  assign wgt_bram_addra             = r_w_addr;
  assign h_data_bram_load_done      = r_done[0];
  assign h_node_info_bram_load_done = r_done[1];
  assign wgt_bram_load_done         = r_done[2];

endmodule

// File: tb/tb_gat_bram_loader.sv
// Randomized bench for gat_bram_loader with small region depths and a beat-list reference model.
module tb_gat_bram_loader;
  localparam int HD = 4;
  localparam int ND = 3;
  localparam int WD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [2:0]  load_mask;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] h_din, ni_din, w_din;
  logic        h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
  logic [3:0]  h_addr;
  logic [3:0]  ni_addr;
  logic [2:0]  w_addr;
  logic        h_done, ni_done, w_done;
  logic        loader_busy, loader_err;

  gat_bram_loader #(
    .H_DATA_DEPTH    (HD),
    .NODE_INFO_DEPTH (ND),
    .WEIGHT_DEPTH    (WD)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .load_start                 (load_start),
    .load_mask                  (load_mask),
    .s_tdata                    (s_tdata),
    .s_tvalid                   (s_tvalid),
    .s_tlast                    (s_tlast),
    .s_tready                   (s_tready),
    .h_data_bram_din            (h_din),
    .h_data_bram_ena            (h_ena),
    .h_data_bram_wea            (h_wea),
    .h_data_bram_addra          (h_addr),
    .h_node_info_bram_din       (ni_din),
    .h_node_info_bram_ena       (ni_ena),
    .h_node_info_bram_wea       (ni_wea),
    .h_node_info_bram_addra     (ni_addr),
    .wgt_bram_din               (w_din),
    .wgt_bram_ena               (w_ena),
    .wgt_bram_wea               (w_wea),
    .wgt_bram_addra             (w_addr),
    .h_data_bram_load_done      (h_done),
    .h_node_info_bram_load_done (ni_done),
    .wgt_bram_load_done         (w_done),
    .loader_busy                (loader_busy),
    .loader_err                 (loader_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] q_exp[$];
  logic [2:0]  mdone = 3'b000;
  logic        merr  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int depth_of(input int r);
    case (r)
      0:       return HD;
      1:       return ND;
      default: return WD;
    endcase
  endfunction

  function automatic int beats_of(input logic [2:0] mask);
    int n = 0;
    for (int r = 0; r < 3; r++) if (mask[r]) n += depth_of(r);
    return n;
  endfunction

  function automatic logic [63:0] pack_wr(input int r, input int addr, input logic [31:0] d,
                                          input logic dn);
    return {21'd0, 2'(r), 8'(addr), d, dn};
  endfunction

  function automatic logic [63:0] outs_or();
    return {47'd0, |h_din, h_ena, h_wea, |h_addr, |ni_din, ni_ena, ni_wea, |ni_addr,
            |w_din, w_ena, w_wea, |w_addr, h_done, ni_done, w_done, loader_busy, loader_err};
  endfunction

  task automatic see_write(input int r, input int addr, input logic [31:0] d, input logic dn);
    if (q_exp.size() == 0) check("write_expected", 64'(q_exp.size() != 0), 64'd1);
    else                   check("write", pack_wr(r, addr, d, dn), q_exp.pop_front());
  endtask

  // Write scoreboard: every strobe must match the next expected beat, including the done level at that moment.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (h_ena | ni_ena | w_ena | h_wea | ni_wea | w_wea) begin
        check("ena_eq_wea", {h_ena, ni_ena, w_ena}, {h_wea, ni_wea, w_wea});
        check("one_port", 32'(h_ena) + 32'(ni_ena) + 32'(w_ena), 1);
      end
      if (h_ena)  see_write(0, int'(h_addr),  h_din,  h_done);
      if (ni_ena) see_write(1, int'(ni_addr), ni_din, ni_done);
      if (w_ena)  see_write(2, int'(w_addr),  w_din,  w_done);
    end
  end

  task automatic end_checks();
    repeat (3) @(negedge clk);
    check("pending", q_exp.size(), 0);
    check("done_flags", {w_done, ni_done, h_done}, mdone);
    check("err", loader_err, merr);
    check("busy", loader_busy, 0);
    check("tready_idle", s_tready, 0);
  endtask

  // err_beat: -1 none, else index of an early tlast; stall: 0 none, 1 toggle, 2 random
  task automatic run_load(input logic [2:0] mask, input int err_beat, input bit err_missing,
                          input int stall, input bit seq_data, input bit poke, input int abort_at);
    int reg_q[$];
    int word_q[$];
    int n, e, last;
    @(negedge clk);
    load_start = 1'b1;
    load_mask  = mask;
    @(negedge clk);
    load_start = 1'b0;
    load_mask  = 3'($urandom);
    merr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (mask[r]) begin
        mdone[r] = 1'b0;
        for (int w = 0; w < depth_of(r); w++) begin
          reg_q.push_back(r);
          word_q.push_back(w);
        end
      end
    end
    n    = reg_q.size();
    e    = err_missing ? n - 1 : err_beat;
    last = (e >= 0) ? e : n - 1;
    for (int b = 0; b <= last; b++) begin
      logic [31:0] d;
      logic        fin, good;
      int          waited;
      d    = seq_data ? 32'(b + 1) : $urandom;
      fin  = (word_q[b] == depth_of(reg_q[b]) - 1);
      good = (b != e);
      if (stall == 1 || (stall == 2 && $urandom_range(0, 2) == 0)) begin
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        s_tlast  = 1'($urandom);
        @(negedge clk);
      end
      q_exp.push_back(pack_wr(reg_q[b], word_q[b] * 4, d, fin && good));
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = err_missing ? 1'b0 : ((e >= 0) ? (b == e) : (b == n - 1));
      if (poke && b == 1) begin
        load_start = 1'b1;
        load_mask  = 3'b111;
      end
      waited = 0;
      while (s_tready !== 1'b1 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (s_tready !== 1'b1) begin
        check("tready_timeout", s_tready, 1);
        s_tvalid   = 1'b0;
        load_start = 1'b0;
        q_exp.delete();
        return;
      end
      @(negedge clk);
      load_start = 1'b0;
      if (fin && good) mdone[reg_q[b]] = 1'b1;
      if (b == abort_at) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs", outs_or(), 0);
        mdone = 3'b000;
        merr  = 1'b0;
        q_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset_outs", outs_or(), 0);
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (e >= 0) merr = 1'b1;
    end_checks();
  endtask

  task automatic pulse_empty_mask();
    @(negedge clk);
    load_start = 1'b1;
    load_mask  = 3'b000;
    @(negedge clk);
    load_start = 1'b0;
    end_checks();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_mask  = 3'b000;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tlast    = 1'b0;
    #3 check("reset_outs", outs_or(), 0);
    check("reset_tready", s_tready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_outs", outs_or(), 0);

    run_load(3'b111, -1, 1'b0, 0, 1'b1, 1'b0, -1);   // full sequence, data 1..9
    run_load(3'b100, -1, 1'b0, 0, 1'b0, 1'b0, -1);   // weights only, H/NI done kept
    run_load(3'b111, -1, 1'b0, 1, 1'b1, 1'b0, -1);   // valid toggling every cycle
    run_load(3'b111,  2, 1'b0, 0, 1'b1, 1'b0, -1);   // early tlast on beat 3
    pulse_empty_mask();                              // empty mask leaves ERR untouched
    run_load(3'b111, -1, 1'b0, 0, 1'b0, 1'b0, -1);   // recovery clears err
    run_load(3'b011, -1, 1'b1, 2, 1'b0, 1'b0, -1);   // tlast missing on final beat
    run_load(3'b111, -1, 1'b0, 0, 1'b1, 1'b0,  4);   // reset while in node-info region
    run_load(3'b111, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    run_load(3'b110, -1, 1'b0, 2, 1'b0, 1'b1, -1);   // load_start while busy
    pulse_empty_mask();

    for (int i = 0; i < 30; i++) begin
      logic [2:0] m;
      int         n, sel, eb;
      m   = 3'($urandom_range(1, 7));
      n   = beats_of(m);
      sel = $urandom_range(0, 3);
      eb  = (sel == 0) ? $urandom_range(0, n - 2) : -1;
      run_load(m, eb, sel == 1, $urandom_range(0, 2), 1'b0, 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
